// File: rtl/control_unit_if.sv
// control_unit_if: instruction in, registered RV32I datapath controls out
interface control_unit_if;
    logic [31:0] instr;
    logic        alu_imm_select;
    logic        alu_pc_select;
    logic        alu_mux1_select;
    logic [1:0]  alu_mux2_select;
    logic [3:0]  alu_op_select;
    logic        w_en_rf;
    logic [1:0]  rf_w_select;
    logic        wr_en_dmem;
    logic [3:0]  rw_mode;
    logic        branch;
    logic        jump;
    modport master (
        output instr,
        input  alu_imm_select, alu_pc_select, alu_mux1_select, alu_mux2_select,
        input  alu_op_select, w_en_rf, rf_w_select, wr_en_dmem, rw_mode, branch, jump
    );
    modport slave (
        input  instr,
        output alu_imm_select, alu_pc_select, alu_mux1_select, alu_mux2_select,
        output alu_op_select, w_en_rf, rf_w_select, wr_en_dmem, rw_mode, branch, jump
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: RV32I main decoder with one-cycle registered control outputs
module control_unit (
    input logic          clk,
    input logic          rst_n,
    control_unit_if.slave bus
);
    typedef struct packed {
        logic       imm;
        logic       pc;
        logic       m1;
        logic [1:0] m2;
        logic [3:0] op;
        logic       wrf;
        logic [1:0] rfs;
        logic       wdm;
        logic [3:0] rw;
        logic       br;
        logic       jp;
    } ctrl_t;
    ctrl_t d, q;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       alt, legal_r;
    logic [3:0] ar_op, cmp_op;
    assign opc = bus.instr[6:0];
    assign f3 = bus.instr[14:12];
    assign f7 = bus.instr[31:25];
    assign alt = f7[5] & (opc == 7'b0110011 || f3 == 3'b101);
    assign legal_r = f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
    assign ar_op = f3 == 3'b000 ? {3'b000, alt} :
                   f3 == 3'b001 ? 4'b0010 :
                   f3 == 3'b010 ? 4'b0011 :
                   f3 == 3'b011 ? 4'b0100 :
                   f3 == 3'b100 ? 4'b0101 :
                   f3 == 3'b101 ? {3'b011, alt} :
                   f3 == 3'b110 ? 4'b1000 : 4'b1001;
    assign cmp_op = f3[2] ? {1'b1, f3} : {3'b101, f3[0]};
    always_comb begin
        d = '0;
        case (opc)
            7'b0110011: if (legal_r) begin
                d.op = ar_op;
                d.wrf = 1'b1;
            end
            7'b0010011: begin
                d.imm = 1'b1;
                d.m2 = 2'b01;
                d.op = ar_op;
                d.wrf = 1'b1;
            end
            7'b0000011: if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
                d.imm = 1'b1;
                d.m2 = 2'b01;
                d.wrf = 1'b1;
                d.rfs = 2'b01;
                d.rw = {1'b1, f3};
            end
            7'b0100011: if (!f3[2] && f3 != 3'b011) begin
                d.imm = 1'b1;
                d.m2 = 2'b01;
                d.wdm = 1'b1;
                d.rw = {1'b1, f3};
            end
            7'b1100011: if (f3[2:1] != 2'b01) begin
                d.imm = 1'b1;
                d.op = cmp_op;
                d.br = 1'b1;
            end
            7'b1101111: begin
                d.imm = 1'b1;
                d.pc = 1'b1;
                d.m2 = 2'b01;
                d.wrf = 1'b1;
                d.rfs = 2'b10;
                d.jp = 1'b1;
            end
            7'b1100111: if (f3 == 3'b000) begin
                d.imm = 1'b1;
                d.m2 = 2'b01;
                d.wrf = 1'b1;
                d.rfs = 2'b10;
                d.jp = 1'b1;
            end
            7'b0110111: begin
                d.imm = 1'b1;
                d.m1 = 1'b1;
                d.m2 = 2'b01;
                d.wrf = 1'b1;
            end
            7'b0010111: begin
                d.imm = 1'b1;
                d.pc = 1'b1;
                d.m2 = 2'b01;
                d.wrf = 1'b1;
            end
            default: d = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else q <= d;
    end
    assign bus.alu_imm_select = q.imm;
    assign bus.alu_pc_select = q.pc;
    assign bus.alu_mux1_select = q.m1;
    assign bus.alu_mux2_select = q.m2;
    assign bus.alu_op_select = q.op;
    assign bus.w_en_rf = q.wrf;
    assign bus.rf_w_select = q.rfs;
    assign bus.wr_en_dmem = q.wdm;
    assign bus.rw_mode = q.rw;
    assign bus.branch = q.br;
    assign bus.jump = q.jp;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed decode vectors with hand-computed control words
module tb_control_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    control_unit_if bus ();
    control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    logic [18:0] got;
    assign got = {bus.alu_imm_select, bus.alu_pc_select, bus.alu_mux1_select, bus.alu_mux2_select,
                  bus.alu_op_select, bus.w_en_rf, bus.rf_w_select, bus.wr_en_dmem, bus.rw_mode,
                  bus.branch, bus.jump};
    function automatic logic [18:0] pk(input logic imm, input logic pc, input logic m1,
                                       input logic [1:0] m2, input logic [3:0] op, input logic wrf,
                                       input logic [1:0] rfs, input logic wdm, input logic [3:0] rw,
                                       input logic br, input logic jp);
        return {imm, pc, m1, m2, op, wrf, rfs, wdm, rw, br, jp};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask
    task automatic apply(input logic [31:0] i);
        @(negedge clk);
        bus.instr = i;
        @(posedge clk);
        #1;
    endtask
    localparam int N = 26;
    logic [31:0] vi [N];
    logic [18:0] ve [N];
    initial begin
        vi[0]  = 32'h00418133; ve[0]  = pk(0,0,0,2'b00,4'b0000,1,2'b00,0,4'b0000,0,0);
        vi[1]  = 32'h40418133; ve[1]  = pk(0,0,0,2'b00,4'b0001,1,2'b00,0,4'b0000,0,0);
        vi[2]  = 32'h0041F133; ve[2]  = pk(0,0,0,2'b00,4'b1001,1,2'b00,0,4'b0000,0,0);
        vi[3]  = 32'h4041D133; ve[3]  = pk(0,0,0,2'b00,4'b0111,1,2'b00,0,4'b0000,0,0);
        vi[4]  = 32'h00822183; ve[4]  = pk(1,0,0,2'b01,4'b0000,1,2'b01,0,4'b1010,0,0);
        vi[5]  = 32'h0041A623; ve[5]  = pk(1,0,0,2'b01,4'b0000,0,2'b00,1,4'b1010,0,0);
        vi[6]  = 32'h0041D663; ve[6]  = pk(1,0,0,2'b00,4'b1101,0,2'b00,0,4'b0000,1,0);
        vi[7]  = 32'h000001EF; ve[7]  = pk(1,1,0,2'b01,4'b0000,1,2'b10,0,4'b0000,0,1);
        vi[8]  = 32'h00002537; ve[8]  = pk(1,0,1,2'b01,4'b0000,1,2'b00,0,4'b0000,0,0);
        vi[9]  = 32'h00001297; ve[9]  = pk(1,1,0,2'b01,4'b0000,1,2'b00,0,4'b0000,0,0);
        vi[10] = 32'h00000000; ve[10] = '0;
        vi[11] = 32'h40419133; ve[11] = '0;
        vi[12] = 32'h40315093; ve[12] = pk(1,0,0,2'b01,4'b0111,1,2'b00,0,4'b0000,0,0);
        vi[13] = 32'h00414093; ve[13] = pk(1,0,0,2'b01,4'b0101,1,2'b00,0,4'b0000,0,0);
        vi[14] = 32'h40010093; ve[14] = pk(1,0,0,2'b01,4'b0000,1,2'b00,0,4'b0000,0,0);
        vi[15] = 32'h000100E7; ve[15] = pk(1,0,0,2'b01,4'b0000,1,2'b10,0,4'b0000,0,1);
        vi[16] = 32'h000110E7; ve[16] = '0;
        vi[17] = 32'h0041E663; ve[17] = pk(1,0,0,2'b00,4'b1110,0,2'b00,0,4'b0000,1,0);
        vi[18] = 32'h0041A663; ve[18] = '0;
        vi[19] = 32'h00823183; ve[19] = '0;
        vi[20] = 32'h00824183; ve[20] = pk(1,0,0,2'b01,4'b0000,1,2'b01,0,4'b1100,0,0);
        vi[21] = 32'h0041B623; ve[21] = '0;
        vi[22] = 32'h00418131; ve[22] = '0;
        vi[23] = 32'h02418133; ve[23] = '0;
        vi[24] = 32'h00418063; ve[24] = pk(1,0,0,2'b00,4'b1010,0,2'b00,0,4'b0000,1,0);
        vi[25] = 32'h00419063; ve[25] = pk(1,0,0,2'b00,4'b1011,0,2'b00,0,4'b0000,1,0);
        bus.instr = 32'h0041A623;
        #1;
        chk("reset_state", 32'(got), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held", 32'(got), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_edge_load", 32'(got), 32'(ve[5]));
        apply(vi[0]);
        @(negedge clk);
        bus.instr = vi[4];
        #1;
        chk("latency_hold", 32'(got), 32'(ve[0]));
        @(posedge clk);
        #1;
        chk("latency_load", 32'(got), 32'(ve[4]));
        for (int k = 0; k < N; k++) begin
            apply(vi[k]);
            chk($sformatf("vec%0d_%h", k, vi[k]), 32'(got), 32'(ve[k]));
        end
        apply(vi[5]);
        chk("sw_wr_en_dmem", 32'(bus.wr_en_dmem), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", 32'(bus.wr_en_dmem), 32'h0);
        chk("async_rst_all", 32'(got), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_edge", 32'(got), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_pre_edge", 32'(got), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_release_load", 32'(got), 32'(ve[5]));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
